// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback arbiter: round-robin sharing of one write port among
// NREQ requesters, a registered write stage, and a pending-write scoreboard.
module rf_writeback_ctrl #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 stall,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_rd,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    output logic                 rs_busy,
    output logic                 rt_busy,
    output logic [(1<<AW)-1:0]   busy_vec,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_rd,
    output logic [DW-1:0]        rf_wdata
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (NREQ > 2) ? 2 : 1;

    logic [PW-1:0]   r_rr_ptr;
    logic            r_rf_we;
    logic [AW-1:0]   r_rf_rd;
    logic [DW-1:0]   r_rf_wdata;
    logic [NREG-1:0] r_busy;

    logic            w_found;
    logic            w_fire;
    logic [PW-1:0]   w_grant_idx;
    logic [NREQ-1:0] w_grant;
    logic [AW-1:0]   w_sel_rd;
    logic [DW-1:0]   w_sel_data;
    logic [NREG-1:0] w_busy_next;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        // Walk the requesters starting just after the last winner.
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_valid[i] && ((int'(r_rr_ptr) + k) % NREQ == i)) begin
                    w_found     = 1'b1;
                    w_grant_idx = PW'(i);
                end
            end
        end
    end

    always_comb begin
        w_grant    = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_grant[i] = w_found && (w_grant_idx == PW'(i));
            if (w_grant[i]) begin
                w_sel_rd   = req_rd[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign w_fire    = w_found && !stall;
    assign req_ready = reset ? '0 : (w_grant & {NREQ{~stall}});

    // A reservation landing on the commit edge of the same register must survive.
    always_comb begin
        w_busy_next = r_busy;
        if (r_rf_we) begin
            w_busy_next[r_rf_rd] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            w_busy_next[rsv_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= PW'(NREQ - 1);
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
            // NOTE: the scoreboard is state the issue logic trusts, so it is
            // reset like a register file rather than left uninitialised.
            r_busy     <= '0;
        end else begin
            r_rf_we <= w_fire && (w_sel_rd != '0);
            if (w_fire) begin
                r_rr_ptr   <= w_grant_idx;
                r_rf_rd    <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
            r_busy <= w_busy_next;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;
    assign busy_vec = r_busy;
    assign rs_busy  = r_busy[rs];
    assign rt_busy  = r_busy[rt];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed scenarios plus random
// traffic, all checked every cycle against a behavioural model.
module tb_rf_writeback_ctrl;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   t_valid;
    logic [AW-1:0]     t_rd   [NREQ];
    logic [DW-1:0]     t_data [NREQ];
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              stall;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_rd;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic              rs_busy;
    logic              rt_busy;
    logic [31:0]       busy_vec;
    logic              rf_we;
    logic [AW-1:0]     rf_rd;
    logic [DW-1:0]     rf_wdata;

    assign req_rd   = {t_rd[2], t_rd[1], t_rd[0]};
    assign req_data = {t_data[2], t_data[1], t_data[0]};

    rf_writeback_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(t_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .stall(stall), .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy), .busy_vec(busy_vec),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: last-winner index, pending write, busy bits.
    int          m_ptr;
    bit          m_we;
    int          m_rd;
    logic [31:0] m_data;
    bit [31:0]   m_busy;

    // Values observed at the last negedge.
    logic [2:0]  o_ready;
    logic        o_we;
    logic [4:0]  o_rd;
    logic [31:0] o_wdata;
    logic [31:0] o_busy;
    logic        o_rs;
    logic        o_rt;

    task automatic model_reset();
        m_ptr  = NREQ - 1;
        m_we   = 0;
        m_rd   = 0;
        m_data = '0;
        m_busy = '0;
    endtask

    task automatic idle_inputs();
        t_valid   = '0;
        stall     = 1'b0;
        rsv_valid = 1'b0;
        rsv_rd    = '0;
        rs        = '0;
        rt        = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_rd[i]   = '0;
            t_data[i] = '0;
        end
    endtask

    // One clock period: check everything at negedge, advance model at posedge.
    task automatic cycle();
        int         g;
        bit         found;
        logic [2:0] e_ready;
        found = 0;
        g     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (!found && t_valid[c]) begin
                found = 1;
                g     = c;
            end
        end
        e_ready = (found && !stall) ? 3'(1 << g) : 3'b000;
        @(negedge clk);
        o_ready = req_ready; o_we = rf_we; o_rd = rf_rd; o_wdata = rf_wdata;
        o_busy = busy_vec; o_rs = rs_busy; o_rt = rt_busy;
        n_cmp++;
        if (o_ready !== e_ready) begin
            n_err++; $display("FAIL model_ready: got %b want %b @%0t", o_ready, e_ready, $time);
        end
        n_cmp++;
        if (o_we !== m_we) begin
            n_err++; $display("FAIL model_rf_we: got %b want %b @%0t", o_we, m_we, $time);
        end
        n_cmp++;
        if (o_rd !== 5'(m_rd) || o_wdata !== m_data) begin
            n_err++; $display("FAIL model_rf_cmd: got rd=%0d data=%h want rd=%0d data=%h @%0t",
                              o_rd, o_wdata, m_rd, m_data, $time);
        end
        n_cmp++;
        if (o_busy !== m_busy) begin
            n_err++; $display("FAIL model_busy_vec: got %h want %h @%0t", o_busy, m_busy, $time);
        end
        n_cmp++;
        if (o_rs !== m_busy[rs] || o_rt !== m_busy[rt]) begin
            n_err++; $display("FAIL model_rs_rt_busy: got %b%b want %b%b @%0t",
                              o_rs, o_rt, m_busy[rs], m_busy[rt], $time);
        end
        if (m_we) m_busy[m_rd] = 0;
        if (rsv_valid && rsv_rd != 0) m_busy[rsv_rd] = 1;
        m_we = found && !stall && (t_rd[g] != 0);
        if (found && !stall) begin
            m_rd   = t_rd[g];
            m_data = t_data[g];
            m_ptr  = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset   = 1'b1;
        t_valid = 3'b111;
        rs      = 5'd3;
        #2;
        n_cmp++;
        if (req_ready !== 3'b000 || rf_we !== 1'b0 || rs_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: ready=%b we=%b rs_busy=%b want 000/0/0", req_ready, rf_we, rs_busy);
        end
        n_cmp++;
        if (rf_rd !== 5'd0 || rf_wdata !== 32'd0 || busy_vec !== 32'd0) begin
            n_err++; $display("FAIL reset_regs: rd=%0d data=%h busy=%h want zeros", rf_rd, rf_wdata, busy_vec);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ready [4];
        logic [4:0] exp_rd    [4];
        exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_rd    = '{5'd1, 5'd2, 5'd3, 5'd1};
        t_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            t_rd[i]   = 5'(i + 1);
            t_data[i] = 32'hAAAA_0000 + 32'(i);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) t_valid = '0;
            cycle();
            if (i < 4) begin
                n_cmp++;
                if (o_ready !== exp_ready[i]) begin
                    n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, o_ready, exp_ready[i]);
                end
            end
            if (i >= 1) begin
                n_cmp++;
                if (o_we !== 1'b1 || o_rd !== exp_rd[i-1]) begin
                    n_err++; $display("FAIL rr_write%0d: got we=%b rd=%0d want we=1 rd=%0d", i, o_we, o_rd, exp_rd[i-1]);
                end
            end
        end
        cycle();
    endtask

    task automatic test_rd_zero();
        rsv_valid = 1'b1; rsv_rd = 5'd4;
        cycle();
        rsv_valid = 1'b0;
        t_valid = 3'b010; t_rd[1] = 5'd0; t_data[1] = 32'h0000_DEAD;
        cycle();
        n_cmp++;
        if (o_ready !== 3'b010) begin
            n_err++; $display("FAIL rd0_ready: got %b want 010", o_ready);
        end
        t_valid = '0;
        cycle();
        n_cmp++;
        if (o_we !== 1'b0 || o_busy !== 32'h0000_0010) begin
            n_err++; $display("FAIL rd0_drop: got we=%b busy=%h want we=0 busy=00000010", o_we, o_busy);
        end
    endtask

    task automatic test_reserve_commit();
        rsv_valid = 1'b1; rsv_rd = 5'd5; rs = 5'd5;
        cycle();
        rsv_valid = 1'b0;
        cycle();
        n_cmp++;
        if (o_rs !== 1'b1) begin
            n_err++; $display("FAIL rsv_busy_c1: got %b want 1", o_rs);
        end
        t_valid = 3'b100; t_rd[2] = 5'd5; t_data[2] = 32'h0000_1234;
        cycle();
        n_cmp++;
        if (o_rs !== 1'b1 || o_ready !== 3'b100) begin
            n_err++; $display("FAIL rsv_busy_c2: got busy=%b ready=%b want 1/100", o_rs, o_ready);
        end
        t_valid = '0;
        cycle();
        n_cmp++;
        if (o_rs !== 1'b1 || o_we !== 1'b1 || o_rd !== 5'd5 || o_wdata !== 32'h0000_1234) begin
            n_err++; $display("FAIL rsv_commit_c3: got busy=%b we=%b rd=%0d data=%h want 1/1/5/00001234",
                              o_rs, o_we, o_rd, o_wdata);
        end
        cycle();
        n_cmp++;
        if (o_rs !== 1'b0) begin
            n_err++; $display("FAIL rsv_clear_c4: got %b want 0", o_rs);
        end
    endtask

    task automatic test_set_clear_same_edge();
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        cycle();
        rsv_valid = 1'b0;
        t_valid = 3'b001; t_rd[0] = 5'd7; t_data[0] = 32'h0000_7777;
        cycle();
        t_valid = '0;
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        cycle();
        n_cmp++;
        if (o_we !== 1'b1 || o_rd !== 5'd7) begin
            n_err++; $display("FAIL same_edge_commit: got we=%b rd=%0d want 1/7", o_we, o_rd);
        end
        rsv_valid = 1'b0;
        cycle();
        n_cmp++;
        if (o_busy[7] !== 1'b1) begin
            n_err++; $display("FAIL same_edge_set_wins: got busy[7]=%b want 1", o_busy[7]);
        end
    endtask

    task automatic test_stall();
        t_valid = 3'b100; t_rd[2] = 5'd10; t_data[2] = 32'h0000_0A0A;
        t_rd[0] = 5'd11; t_data[0] = 32'h0000_0B0B;
        cycle();
        n_cmp++;
        if (o_ready !== 3'b100) begin
            n_err++; $display("FAIL stall_pre_grant: got %b want 100", o_ready);
        end
        t_valid = 3'b101; stall = 1'b1;
        rsv_valid = 1'b1; rsv_rd = 5'd12;
        for (int i = 0; i < 3; i++) begin
            cycle();
            rsv_valid = 1'b0;
            n_cmp++;
            if (o_ready !== 3'b000 || o_we !== (i == 0)) begin
                n_err++; $display("FAIL stall_cycle%0d: got ready=%b we=%b want 000/%0d", i, o_ready, o_we, (i == 0));
            end
        end
        n_cmp++;
        if (o_busy[12] !== 1'b1) begin
            n_err++; $display("FAIL stall_scoreboard: got busy[12]=%b want 1", o_busy[12]);
        end
        stall = 1'b0;
        cycle();
        n_cmp++;
        if (o_ready !== 3'b001) begin
            n_err++; $display("FAIL stall_release_grant: got %b want 001", o_ready);
        end
        t_valid = '0;
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            t_valid = 3'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                t_rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                t_data[i] = $urandom;
            end
            stall     = ($urandom_range(0, 4) == 0);
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_rd    = 5'($urandom_range(0, 31));
            rs        = 5'($urandom_range(0, 31));
            rt        = 5'($urandom_range(0, 31));
            cycle();
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset_mid();
        rsv_valid = 1'b1; rsv_rd = 5'd9; rs = 5'd9;
        cycle();
        rsv_valid = 1'b0;
        t_valid = 3'b010; t_rd[1] = 5'd9; t_data[1] = 32'h0000_0909;
        cycle();
        n_cmp++;
        if (o_ready !== 3'b010) begin
            n_err++; $display("FAIL mid_pre_grant: got %b want 010", o_ready);
        end
        t_valid = 3'b111;
        #3;
        n_cmp++;
        if (rf_we !== 1'b1 || busy_vec[9] !== 1'b1) begin
            n_err++; $display("FAIL mid_pre_state: got we=%b busy[9]=%b want 1/1", rf_we, busy_vec[9]);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0 || busy_vec !== 32'd0 || req_ready !== 3'b000 || rs_busy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got we=%b busy=%h ready=%b rs_busy=%b want 0/0/000/0",
                              rf_we, busy_vec, req_ready, rs_busy);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        t_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) t_rd[i] = 5'(i + 1);
        cycle();
        n_cmp++;
        if (o_ready !== 3'b001) begin
            n_err++; $display("FAIL mid_post_priority: got %b want 001", o_ready);
        end
        idle_inputs();
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_rd_zero();
        test_reserve_commit();
        test_set_clear_same_edge();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
